// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word memory behind request/response valid/ready handshakes
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            wr;
    logic            err;
    logic [AW-1:0]   idx;
    logic [31:0]     wdata;
    logic [31:0]     mem [DEPTH_WORDS];
    logic            commit;

    assign commit = state == WAIT && cnt == '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            cnt        <= '0;
            wr         <= 1'b0;
            err        <= 1'b0;
            idx        <= '0;
            wdata      <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    wr        <= req_write;
                    idx       <= req_addr[AW+1:2];
                    wdata     <= req_wdata;
                    err       <= req_addr[1:0] != 2'b00 || (req_addr >> (AW + 2)) != 32'd0;
                    cnt       <= CW'(LATENCY - 1);
                    req_ready <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: if (commit) begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= err;
                    resp_rdata <= (err || wr) ? '0 : mem[idx];
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESP: if (resp_ready) begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // kept reset-free so it maps to RAM; reset only blocks a commit landing on the same edge
    always_ff @(posedge clk) begin
        if (commit && wr && !err && !reset)
            mem[idx] <= wdata;
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (LATENCY=2 main instance, LATENCY=1 burst instance)
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_valid1 = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b1;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        req_ready1, resp_valid1, resp_err1;
    logic [31:0] resp_rdata1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [31:0] mdl [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_rdata(resp_rdata1),
        .resp_err(resp_err1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push0(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic e;
        logic [31:0] r;
        e = a[1:0] != 2'b00 || a >= 32'h400;
        r = (w || e) ? 32'h0 : mdl[int'(a >> 2)];
        q0.push_back({e, r});
        if (w && !e) mdl[int'(a >> 2)] = d;
    endtask

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output int busy, output int pulses);
        lat = 0;
        busy = 0;
        pulses = 0;
        for (int n = 0; n < 50 && !req_ready; n++) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        push0(w, a, d);
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (n == 1) req_valid = 1'b0;
            if (resp_valid) begin
                pulses++;
                if (lat == 0) lat = n;
            end
            if (req_ready) begin
                busy = n;
                break;
            end
        end
    endtask

    task automatic burst1(input logic w, input int base);
        int last;
        int k;
        last = 0;
        k = 0;
        req_write = w;
        for (int n = 0; n < 60 && k < 4; n++) begin
            @(posedge clk); #1;
            if (req_ready1) begin
                if (k > 0) check("t6_gap", cyc - last, 3);
                last = cyc;
                req_valid1 = 1'b1;
                req_addr   = (base + k) * 4;
                req_wdata  = 32'hC0DE0000 + k;
                q1.push_back(w ? 33'h0 : {1'b0, 32'hC0DE0000 + k});
                k++;
            end
        end
        @(posedge clk); #1;
        req_valid1 = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && resp_valid && resp_ready) begin
            if (q0.size() == 0) check("u0_extra_resp", 1, 0);
            else check("u0_resp", {resp_err, resp_rdata}, q0.pop_front());
        end
        if (!reset && resp_valid1 && resp_ready) begin
            if (q1.size() == 0) check("u1_extra_resp", 1, 0);
            else check("u1_resp", {resp_err1, resp_rdata1}, q1.pop_front());
        end
    end

    initial begin
        int lat, busy, pulses;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", resp_err, 0);
        reset = 1'b0;

        txn(1'b1, 32'h10, 32'hDEADBEEF, lat, busy, pulses);
        check("t1_lat", lat, 3);
        check("t1_busy_period", busy, 4);
        check("t1_pulses", pulses, 1);

        txn(1'b0, 32'h10, 32'h0, lat, busy, pulses);
        check("t2_lat", lat, 3);

        txn(1'b1, 32'h0, 32'hA5A5A5A5, lat, busy, pulses);
        txn(1'b1, 32'h20, 32'h5555, lat, busy, pulses);
        txn(1'b1, 32'h30, 32'h77, lat, busy, pulses);
        txn(1'b0, 32'h13, 32'h0, lat, busy, pulses);
        txn(1'b1, 32'h400, 32'hBADBAD, lat, busy, pulses);
        txn(1'b0, 32'h0, 32'h0, lat, busy, pulses);

        // hold the response back while offering an extra store that must be ignored
        resp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        push0(1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int n = 0; n < 20 && !resp_valid; n++) begin
            @(posedge clk); #1;
        end
        check("t4_valid", resp_valid, 1);
        repeat (5) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 32'h30;
            req_wdata = 32'hBAD;
            @(posedge clk); #1;
            check("t4_hold_valid", resp_valid, 1);
            check("t4_hold_data", resp_rdata, 32'hDEADBEEF);
            check("t4_no_accept", req_ready, 0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_idle_ready", req_ready, 1);
        check("t4_idle_valid", resp_valid, 0);
        txn(1'b0, 32'h30, 32'h0, lat, busy, pulses);

        // reset lands in the first WAIT cycle of a store
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t5_req_ready", req_ready, 1);
        check("t5_resp_valid", resp_valid, 0);
        check("t5_rdata", resp_rdata, 0);
        check("t5_err", resp_err, 0);
        repeat (3) @(posedge clk);
        #1;
        txn(1'b0, 32'h20, 32'h0, lat, busy, pulses);

        burst1(1'b1, 8);
        burst1(1'b0, 8);

        for (int n = 0; n < 50 && (q0.size() != 0 || q1.size() != 0); n++) begin
            @(posedge clk); #1;
        end
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
